// File: rtl/regfile_pkg.sv
// Shared defaults, reset-preset table and popcount helper for register_file_sb.
package regfile_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned NREGS_DEF  = 32;

  // Widest busy vector the popcount helper accepts; NREGS must not exceed it.
  localparam int unsigned POPCNT_MAX = 1024;

  // Registers 1..7 come out of reset with these values; everything else is 0.
  localparam int unsigned NPRESET    = 7;

  typedef struct packed {
    logic [7:0]  idx;
    logic [31:0] val;
  } preset_t;

  localparam preset_t PRESET_TBL [NPRESET] = '{
    '{idx: 8'd1, val: 32'd10},
    '{idx: 8'd2, val: 32'd5},
    '{idx: 8'd3, val: 32'd7},
    '{idx: 8'd4, val: 32'd1},
    '{idx: 8'd5, val: 32'd2},
    '{idx: 8'd6, val: 32'd3},
    '{idx: 8'd7, val: 32'd4}
  };

  // Number of set bits; callers zero-extend their vector to POPCNT_MAX.
  function automatic int unsigned popcount(input logic [POPCNT_MAX-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < POPCNT_MAX; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: hazard stall, set/clear priority, busy count.
// Optional macro REGFILE_WB_BYPASS_EN: busy bits cleared by a same-cycle
// write-back do not cause a stall.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned NREGS = NREGS_DEF,
  localparam int unsigned AW    = $clog2(NREGS),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1_i,
  input  logic [AW-1:0] rs2_i,
  input  logic          issue_valid_i,
  input  logic [AW-1:0] issue_rd_i,
  input  logic          wb0_valid_i,
  input  logic [AW-1:0] wb0_rd_i,
  input  logic          wb1_valid_i,
  input  logic [AW-1:0] wb1_rd_i,
  output logic          stall_c_o,
  output logic [CW-1:0] busy_cnt_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] clr_mask, set_mask, busy_eff;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Hazard detection and next busy vector; a new producer's set beats a clear.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (wb0_valid_i) clr_mask[wb0_rd_i] = 1'b1;
    if (wb1_valid_i) clr_mask[wb1_rd_i] = 1'b1;
`ifdef REGFILE_WB_BYPASS_EN
    busy_eff = busy_q & ~clr_mask;
`else
    busy_eff = busy_q;
`endif
    stall_c_o = issue_valid_i &
                (busy_eff[rs1_i] | busy_eff[rs2_i] | busy_eff[issue_rd_i]);
    if (issue_valid_i && !stall_c_o && (issue_rd_i != '0)) begin
      set_mask[issue_rd_i] = 1'b1;
    end
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
    cnt_d     = CW'(popcount(POPCNT_MAX'(busy_d)));
  end

  // Busy vector and its count register together so the count tracks busy_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/register_file_sb.sv
// Parametrised register file: two async read ports, two write-back lanes,
// busy scoreboard for RAW/WAW stalls.
// Optional macro REGFILE_WB_BYPASS_EN: same-cycle write-back forwarding on
// the read ports and no stall on a register being written back this cycle.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN  = XLEN_DEF,
  parameter  int unsigned NREGS = NREGS_DEF,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            stall,
  input  logic            wb0_valid,
  input  logic [AW-1:0]   wb0_rd,
  input  logic [XLEN-1:0] wb0_data,
  input  logic            wb1_valid,
  input  logic [AW-1:0]   wb1_rd,
  input  logic [XLEN-1:0] wb1_data,
  output logic [AW:0]     busy_cnt
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Write-back merge; lane 1 is applied last so it wins on a shared rd.
  always_comb begin
    regs_d = regs_q;
    if (wb0_valid && (wb0_rd != '0)) regs_d[wb0_rd] = wb0_data;
    if (wb1_valid && (wb1_rd != '0)) regs_d[wb1_rd] = wb1_data;
  end

  // Storage; reset clears everything then loads the preset table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      for (int unsigned p = 0; p < NPRESET; p++) begin
        regs_q[AW'(PRESET_TBL[p].idx)] <= XLEN'(PRESET_TBL[p].val);
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read muxes; register 0 always reads as zero.
  always_comb begin
    rs1_data = (rs1 == '0) ? '0 : regs_q[rs1];
    rs2_data = (rs2 == '0) ? '0 : regs_q[rs2];
`ifdef REGFILE_WB_BYPASS_EN
    if (rs1 != '0) begin
      if (wb1_valid && (wb1_rd == rs1))      rs1_data = wb1_data;
      else if (wb0_valid && (wb0_rd == rs1)) rs1_data = wb0_data;
    end
    if (rs2 != '0) begin
      if (wb1_valid && (wb1_rd == rs2))      rs2_data = wb1_data;
      else if (wb0_valid && (wb0_rd == rs2)) rs2_data = wb0_data;
    end
`endif
  end

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .rs1_i         (rs1),
    .rs2_i         (rs2),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .wb0_valid_i   (wb0_valid),
    .wb0_rd_i      (wb0_rd),
    .wb1_valid_i   (wb1_valid),
    .wb1_rd_i      (wb1_rd),
    .stall_c_o     (stall),
    .busy_cnt_o    (busy_cnt)
  );

endmodule
